flowstate_update: RTL
=====================

// Module: flowstate_update
// PURPOSE
//  Downstream consumer of the flowstate RAM match port. For each matched TX descriptor it takes the stored
//  flowstate, assigns the current sequence number to the packet, increments it, and broadcasts the new
//  flowstate back to the RAM (bcd_* inputs of the RAM stage). A one-entry forwarding register covers the
//  RAM's one-write read-after-write window. It also keeps hit/miss statistics.
// PARAMETERS
//  FLOWSTATE_WIDTH  32  flowstate word; [31]=flow enable, [30:SEQ_WIDTH]=opaque, [SEQ_WIDTH-1:0]=next seq
//  ADDR_WIDTH       10  flow table address width
//  SEQ_WIDTH        24  sequence number width (<= FLOWSTATE_WIDTH-1)
//  CNT_WIDTH        32  statistics counter width
// PORTS
//  clk               input   1                single clock domain
//  rst               input   1                synchronous reset, active-low (0 = reset)
//  s_mat_hit         input   1                lookup hit flag from RAM stage
//  s_mat_value       input   FLOWSTATE_WIDTH  stored flowstate from RAM stage
//  s_mat_addr        input   ADDR_WIDTH       flow address
//  s_mat_valid       input   1                match result valid
//  s_mat_ready       output  1                match result accepted
//  m_tx_hit          output  1                flow hit and enabled (seq valid)
//  m_tx_seq          output  SEQ_WIDTH        sequence number assigned to packet
//  m_tx_addr         output  ADDR_WIDTH       flow address
//  m_tx_valid        output  1                descriptor valid
//  m_tx_ready        input   1                descriptor accepted downstream
//  bcd_flowstate_out output  FLOWSTATE_WIDTH  updated flowstate to RAM
//  bcd_addr_out      output  ADDR_WIDTH       updated flow address
//  bcd_valid_out     output  1                one-cycle write pulse to RAM
//  csr_wr_in         input   1                any CSR write to flow table this cycle (invalidates forward)
//  stat_clr          input   1                clear statistics counters
//  hit_cnt           output  CNT_WIDTH        accepted hits with flow enabled
//  miss_cnt          output  CNT_WIDTH        accepted misses or disabled hits
// BEHAVIOUR
//  - Reset (rst==0 at posedge): m_tx_valid=0, m_tx_hit=0, m_tx_seq=0, m_tx_addr=0, bcd_valid_out=0,
//    bcd_flowstate_out=0, bcd_addr_out=0, fwd_valid=0, hit_cnt=0, miss_cnt=0. Reset mid-transfer drops
//    held descriptor and any pending broadcast; no pulse is emitted in or after the reset cycle.
//  - Handshake: s_mat_ready = m_tx_ready | ~m_tx_valid (combinational). Accept = s_mat_valid & s_mat_ready.
//    m_tx_valid holds with stable data until m_tx_ready; one accept per cycle max; latency 1 cycle.
//  - Effective state eff = (fwd_valid && fwd_addr==s_mat_addr) ? fwd_value : s_mat_value.
//  - On accept with s_mat_hit && eff[FLOWSTATE_WIDTH-1]: m_tx_hit=1, m_tx_seq=eff[SEQ_WIDTH-1:0];
//    next cycle bcd_valid_out=1, bcd_addr_out=s_mat_addr, bcd_flowstate_out = eff with seq field
//    replaced by (seq+1) mod 2^SEQ_WIDTH (all-ones wraps to 0; upper bits unchanged);
//    fwd_addr/fwd_value/fwd_valid=1 loaded with the same values in that edge. hit_cnt += 1.
//  - On accept with miss or disabled flow: m_tx_hit=0, m_tx_seq=0, no broadcast, fwd unchanged, miss_cnt += 1.
//  - bcd_valid_out is exactly one cycle, independent of m_tx_ready (not held by backpressure).
//  - Forwarding rationale: RAM stage issues the next read on the same edge this block accepts, one cycle
//    before the broadcast write; only the immediately previous update can be stale, so one entry suffices.
//  - csr_wr_in=1: fwd_valid cleared at that edge; if an accept's update loads fwd on the same edge, load wins
//    (broadcast has priority over CSR writes in the RAM).
//  - Counters wrap at 2^CNT_WIDTH; stat_clr zeroes both, and wins over a simultaneous increment.
// TESTING
//  1. Reset, RAM value {1,7'h0,24'd5} hit addr 3, m_tx_ready=1 -> m_tx_seq=5 hit=1 next cycle; bcd pulse addr 3 value seq=6; hit_cnt=1.
//  2. Back-to-back addr 3 hits, second input still carries stale seq 5 -> forwarding gives m_tx_seq 5 then 6, bcd seq 6 then 7.
//  3. seq=24'hFFFFFF hit -> m_tx_seq=FFFFFF, bcd seq=0, bits[31:24] unchanged.
//  4. Miss, then enabled=0 hit -> m_tx_hit=0 seq=0, no bcd pulse, miss_cnt=2, hit_cnt unchanged.
//  5. m_tx_ready=0 for 4 cycles with valid held -> s_mat_ready=0, output stable, single bcd pulse; csr_wr_in then clears forward (next same-addr hit uses RAM value).
//  6. rst=0 while m_tx_valid=1 and bcd pending -> all outputs 0 next cycle, no pulse, counters 0.

Source files
------------

// File: rtl/flowstate_update.sv
// Flowstate update stage: assigns per-flow sequence numbers to matched TX descriptors,
// writes the incremented flowstate back to the RAM and forwards it across the RAW window.
module flowstate_update #(
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int SEQ_WIDTH       = 24,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_mat_hit,
  input  logic [FLOWSTATE_WIDTH-1:0] s_mat_value,
  input  logic [ADDR_WIDTH-1:0]      s_mat_addr,
  input  logic                       s_mat_valid,
  output logic                       s_mat_ready,
  output logic                       m_tx_hit,
  output logic [SEQ_WIDTH-1:0]       m_tx_seq,
  output logic [ADDR_WIDTH-1:0]      m_tx_addr,
  output logic                       m_tx_valid,
  input  logic                       m_tx_ready,
  output logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_out,
  output logic [ADDR_WIDTH-1:0]      bcd_addr_out,
  output logic                       bcd_valid_out,
  input  logic                       csr_wr_in,
  input  logic                       stat_clr,
  output logic [CNT_WIDTH-1:0]       hit_cnt,
  output logic [CNT_WIDTH-1:0]       miss_cnt
);

  logic                       accept;
  logic                       fwd_hit;
  logic                       upd_en;
  logic [FLOWSTATE_WIDTH-1:0] eff_value;
  logic [FLOWSTATE_WIDTH-1:0] upd_value;
  logic [SEQ_WIDTH-1:0]       next_seq;

  logic                       fwd_valid;
  logic [ADDR_WIDTH-1:0]      fwd_addr;
  logic [FLOWSTATE_WIDTH-1:0] fwd_value;

  assign s_mat_ready = m_tx_ready | ~m_tx_valid;
  assign accept      = s_mat_valid & s_mat_ready;

  // The RAM read for this descriptor may predate the last broadcast; prefer the forwarded copy.
  always_comb begin
    fwd_hit   = fwd_valid && (fwd_addr == s_mat_addr);
    eff_value = fwd_hit ? fwd_value : s_mat_value;
    upd_en    = accept && s_mat_hit && eff_value[FLOWSTATE_WIDTH-1];
    next_seq  = eff_value[SEQ_WIDTH-1:0] + SEQ_WIDTH'(1);
    upd_value = eff_value;
    upd_value[SEQ_WIDTH-1:0] = next_seq;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_tx_valid <= 1'b0;
      m_tx_hit   <= 1'b0;
      m_tx_seq   <= '0;
      m_tx_addr  <= '0;
    end else if (accept) begin
      m_tx_valid <= 1'b1;
      m_tx_hit   <= upd_en;
      m_tx_seq   <= upd_en ? eff_value[SEQ_WIDTH-1:0] : '0;
      m_tx_addr  <= s_mat_addr;
    end else if (m_tx_ready) begin
      m_tx_valid <= 1'b0;
    end
  end

  // Broadcast is a single-cycle write pulse, never stretched by downstream backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_valid_out     <= 1'b0;
      bcd_flowstate_out <= '0;
      bcd_addr_out      <= '0;
    end else begin
      bcd_valid_out <= upd_en;
      if (upd_en) begin
        bcd_flowstate_out <= upd_value;
        bcd_addr_out      <= s_mat_addr;
      end
    end
  end

  // A fresh update outranks a CSR write in the RAM, so the load wins over the invalidate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_value <= '0;
    end else if (upd_en) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= s_mat_addr;
      fwd_value <= upd_value;
    end else if (csr_wr_in) begin
      fwd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (upd_en) hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
      else        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
